serial_dedup_converter: RTL and testbench

Parametrised serial-in/serial-out word converter with change detection. It deserialises framed words from a 1-bit input and compares each word with the previously received one. Only changed words go into a DEPTH-entry pending FIFO, which a serialiser re-emits framed on a registered 1-bit output. It is the multi-word, width-configurable successor of the single-buffer 8-bit serial converter in the ITC99-style benchmark set, and sits between two bit-serial links.

---
 rtl/serial_dedup_converter.sv | 180 ++++++++++++++++++
 tb/tb_serial_dedup_converter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_dedup_converter.sv
// Bit-serial word converter: deserialises framed words, suppresses repeats of the previous word,
// queues changed words in a DEPTH-entry FIFO and re-serialises them. Define SERIAL_DEDUP_EN to enable suppression.
module serial_dedup_converter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         X,
    output logic                         Y,
    output logic                         tx_busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         dup,
    output logic                         drop
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        RX_IDLE,
        RX_DATA
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    rx_state_t        rx_state;
    logic [BW-1:0]    rx_cnt;
    logic [WIDTH-2:0] rx_shreg;
    logic [WIDTH-1:0] rx_word;
    logic             rx_done;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    tx_state_t        tx_state;
    logic [BW-1:0]    tx_cnt;
    logic [WIDTH-1:0] tx_shreg;

    logic             is_dup;
    logic             push;
    logic             pop;
    logic             lost;

    // The completed word is the buffered bits plus the bit sampled on the completion edge.
    assign rx_word = {rx_shreg, X};
    assign rx_done = (rx_state == RX_DATA) && (rx_cnt == LAST_BIT);
    assign pop     = (tx_state == TX_IDLE) && (fifo_count != '0);
    assign push    = rx_done && !is_dup && ((fifo_count != FULL_COUNT) || pop);
    assign lost    = rx_done && !is_dup && (fifo_count == FULL_COUNT) && !pop;

`ifdef SERIAL_DEDUP_EN
    logic [WIDTH-1:0] old_word;
    logic             old_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            old_word  <= '0;
            old_valid <= 1'b0;
        end else if (rx_done) begin
            old_word  <= rx_word;
            old_valid <= 1'b1;
        end
    end

    assign is_dup = old_valid && (rx_word == old_word);
`else
    assign is_dup = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shreg <= '0;
            dup      <= 1'b0;
            drop     <= 1'b0;
        end else begin
            dup  <= rx_done && is_dup;
            drop <= lost;
            case (rx_state)
                RX_IDLE: begin
                    if (X) begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= '0;
                    end
                end
                RX_DATA: begin
                    rx_shreg <= rx_word[WIDTH-2:0];
                    rx_cnt   <= rx_cnt + 1'b1;
                    if (rx_cnt == LAST_BIT) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after being written since the last reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= rx_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // tx_busy tracks the bit on Y, so it covers start, data and stop bit cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shreg <= '0;
            Y        <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (pop) begin
                        tx_shreg <= mem[rd_ptr];
                        tx_cnt   <= '0;
                        Y        <= 1'b1;
                        tx_busy  <= 1'b1;
                        tx_state <= TX_DATA;
                    end else begin
                        Y       <= 1'b0;
                        tx_busy <= 1'b0;
                    end
                end
                TX_DATA: begin
                    Y        <= tx_shreg[WIDTH-1];
                    tx_shreg <= tx_shreg << 1;
                    tx_cnt   <= tx_cnt + 1'b1;
                    tx_busy  <= 1'b1;
                    if (tx_cnt == LAST_BIT) begin
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    Y        <= 1'b0;
                    tx_busy  <= 1'b1;
                    tx_state <= TX_IDLE;
                end
                default: begin
                    Y        <= 1'b0;
                    tx_busy  <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_dedup_converter.sv
// Scoreboard bench for serial_dedup_converter: a queue-based reference model predicts FIFO occupancy,
// dup/drop pulses and emitted words with their start edge; a monitor decodes Y and compares.
module tb_serial_dedup_converter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef SERIAL_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          X     = 1'b0;
    logic          Y;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;
    logic          dup;
    logic          drop;

    always #5 clock = ~clock;

    serial_dedup_converter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .X          (X),
        .Y          (Y),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .dup        (dup),
        .drop       (drop)
    );

    typedef struct {
        int               at_edge;
        logic [WIDTH-1:0] word;
    } ev_t;

    int errors = 0;
    int checks = 0;

    ev_t              rx_events[$];
    ev_t              exp_q[$];
    logic [WIDTH-1:0] pend[$];
    int               edge_n    = 0;
    int               tx_ready  = 0;
    logic [WIDTH-1:0] old_word  = '0;
    bit               old_valid = 1'b0;
    bit               m_dup     = 1'b0;
    bit               m_drop    = 1'b0;
    bit               mon_abort = 1'b0;
    bit               checking  = 1'b0;

    int               mon_state = 0;
    int               mon_bits  = 0;
    logic [WIDTH-1:0] mon_word  = '0;
    logic [WIDTH-1:0] mon_exp   = '0;
    int               mon_words = 0;
    int               drop_seen = 0;
    int               dup_seen  = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_n);
        end
    endtask

    // Reference model: the serialiser takes one word every WIDTH+2 edges at most; the
    // full test uses the occupancy before the edge, with a same-edge pop freeing a slot.
    always @(posedge clock) begin
        int  pre;
        bit  popped;
        ev_t e;
        ev_t r;
        edge_n++;
        if (reset) begin
            pend.delete();
            exp_q.delete();
            rx_events.delete();
            old_valid = 1'b0;
            tx_ready  = edge_n + 1;
            m_dup     = 1'b0;
            m_drop    = 1'b0;
            mon_abort = 1'b1;
        end else begin
            pre    = pend.size();
            popped = (edge_n >= tx_ready) && (pre > 0);
            m_dup  = 1'b0;
            m_drop = 1'b0;
            if (popped) begin
                e.word    = pend.pop_front();
                e.at_edge = edge_n;
                exp_q.push_back(e);
                tx_ready = edge_n + WIDTH + 2;
            end
            if (rx_events.size() > 0 && rx_events[0].at_edge == edge_n) begin
                r = rx_events.pop_front();
                if (DEDUP && old_valid && r.word == old_word) begin
                    m_dup = 1'b1;
                end else if (pre < DEPTH || popped) begin
                    pend.push_back(r.word);
                end else begin
                    m_drop = 1'b1;
                end
                old_word  = r.word;
                old_valid = 1'b1;
            end
        end
    end

    // Monitor: per-cycle status comparison plus decoding of frames on Y.
    always @(negedge clock) begin
        ev_t e;
        if (checking) begin
            check_output("fifo_count", int'(fifo_count), pend.size());
            check_output("dup", int'(dup), int'(m_dup));
            check_output("drop", int'(drop), int'(m_drop));
            if (dup)  dup_seen++;
            if (drop) drop_seen++;
            if (mon_abort) begin
                mon_state = 0;
                mon_abort = 1'b0;
            end
            case (mon_state)
                0: begin
                    if (Y) begin
                        if (exp_q.size() == 0) begin
                            check_output("unexpected_start", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check_output("start_edge", edge_n, e.at_edge);
                            check_output("tx_busy_start", int'(tx_busy), 1);
                            mon_exp   = e.word;
                            mon_bits  = 0;
                            mon_state = 1;
                        end
                    end
                end
                1: begin
                    mon_word = {mon_word[WIDTH-2:0], Y};
                    mon_bits++;
                    if (mon_bits == WIDTH) mon_state = 2;
                end
                default: begin
                    check_output("stop_bit", int'(Y), 0);
                    check_output("word", int'(mon_word), int'(mon_exp));
                    mon_words++;
                    mon_state = 0;
                end
            endcase
        end else begin
            mon_abort = 1'b0;
        end
    end

    // Drives one frame; nbits < WIDTH leaves it unfinished so a reset can cut it off.
    task automatic apply_stimulus(input logic [WIDTH-1:0] w, input int gap, input int nbits = WIDTH);
        ev_t e;
        @(negedge clock);
        X = 1'b1;
        if (nbits == WIDTH) begin
            e.at_edge = edge_n + 1 + WIDTH;
            e.word    = w;
            rx_events.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            X = w[WIDTH-1-i];
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            X = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        @(negedge clock);
        X = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            done = (pend.size() == 0) && (exp_q.size() == 0) && (rx_events.size() == 0) && (mon_state == 0);
        end
        if (!done) check_output("idle_timeout", 1, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int m0;
        int d0;
        reset = 1'b1;
        X     = 1'b0;
        repeat (2) @(negedge clock);
        check_output("reset_Y", int'(Y), 0);
        check_output("reset_tx_busy", int'(tx_busy), 0);
        check_output("reset_fifo_count", int'(fifo_count), 0);
        check_output("reset_dup", int'(dup), 0);
        check_output("reset_drop", int'(drop), 0);
        reset    = 1'b0;
        checking = 1'b1;

        apply_stimulus(8'hA5, 0);
        wait_idle();

        d0 = dup_seen;
        apply_stimulus(8'h3C, 3);
        apply_stimulus(8'h3C, 3);
        apply_stimulus(8'h3D, 3);
        wait_idle();
        check_output("dup_pulses", dup_seen - d0, DEDUP ? 1 : 0);

        m0 = mon_words;
        d0 = drop_seen;
        for (int k = 1; k <= 8; k++) apply_stimulus(8'(k), 0);
        wait_idle();
        check_output("emit_plus_drop", (mon_words - m0) + (drop_seen - d0), 8);

        for (int k = 0; k < 60; k++) apply_stimulus(8'($urandom), 0);
        wait_idle();
        for (int k = 0; k < 60; k++) apply_stimulus(8'($urandom_range(0, 3)), $urandom_range(0, 2));
        wait_idle();

        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h3F, 0, 4);
        reset = 1'b1;
        @(negedge clock);
        check_output("midreset_Y", int'(Y), 0);
        check_output("midreset_fifo_count", int'(fifo_count), 0);
        check_output("midreset_tx_busy", int'(tx_busy), 0);
        reset = 1'b0;
        X     = 1'b0;
        m0    = mon_words;
        apply_stimulus(8'h00, 2);
        wait_idle();
        check_output("post_reset_forward", mon_words - m0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
